download_mem_arb: RTL and testbench
===================================

DOWNLOAD_MEM_ARB -- requirements
Module: download_mem_arb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, width of all address buses.
REQ-002 SHALL have parameter DL_DEPTH, default 4, download write buffer entries (power of two, >=2); used only when DL_ARB_FIFO_EN is defined.
REQ-003 SHALL have ports:
  clk  in  1  single system clock, all logic on posedge
  reset_n  in  1  synchronous reset, active-low
  dl_active  in  1  download in progress (level)
  dl_wr  in  1  one-cycle download write strobe
  dl_addr  in  ADDR_WIDTH  download write address
  dl_data  in  8  download write data
  core_req  in  1  core access request (level, held until core_ack)
  core_we  in  1  core write=1, read=0
  core_addr  in  ADDR_WIDTH  core address
  core_wdata  in  8  core write data
  core_ack  out  1  one-cycle completion pulse to core
  core_rdata  out  8  read data, valid with core_ack
  mem_req  out  1  memory request (level)
  mem_we  out  1  memory write enable
  mem_addr  out  ADDR_WIDTH  memory address
  mem_wdata  out  8  memory write data
  mem_ack  in  1  one-cycle memory completion pulse
  mem_rdata  in  8  memory read data, valid with mem_ack
  dl_overflow  out  1  sticky: download write lost

Function
REQ-004 SHALL implement FSM states IDLE, DL_WR, CORE_ACC.
REQ-005 In IDLE, buffer non-empty SHALL take priority over core_req; next state DL_WR, else CORE_ACC if core_req, else IDLE.
REQ-006 While dl_active=1, core_req SHALL NOT be granted; core waits with core_ack=0.
REQ-007 On entry to DL_WR/CORE_ACC, mem_req, mem_we, mem_addr, mem_wdata SHALL be registered and held stable until the cycle mem_ack=1.
REQ-008 On mem_ack, FSM SHALL return to IDLE with mem_req=0 the next cycle; minimum one idle cycle between memory requests.
REQ-009 In CORE_ACC, core_ack SHALL pulse exactly one cycle, the cycle after mem_ack; core_rdata SHALL capture mem_rdata on mem_ack (reads) and hold until next core read.
REQ-010 A dl_wr strobe SHALL be pushed into the buffer the same cycle; the buffer entry SHALL be popped on mem_ack in DL_WR.
REQ-011 dl_wr while buffer full and not popping that cycle SHALL drop the write and set dl_overflow; push and pop in same cycle when full SHALL succeed.
REQ-012 dl_overflow SHALL clear only on reset or on the rising edge of dl_active.
REQ-013 Downloaded bytes SHALL reach memory in strobe order; dl_addr is used as given, no address arithmetic.
REQ-014 mem_ack outside DL_WR/CORE_ACC SHALL be ignored.
REQ-015 Falling dl_active SHALL NOT flush the buffer; remaining entries drain before core is granted.

Reset
REQ-016 On reset_n=0 at posedge clk: FSM IDLE, buffer empty, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, core_ack=0, core_rdata=0, dl_overflow=0.
REQ-017 Reset mid-access SHALL abandon the access immediately; no core_ack issued for it.

Configuration
REQ-018 Macro DL_ARB_FIFO_EN: defined -> DL_DEPTH-entry FIFO buffer; undefined -> single holding register (depth 1), DL_DEPTH ignored, REQ-011 applies with depth 1.

Structure
REQ-019 Shared package dl_arb_pkg SHALL hold the FSM state enum and the write-entry struct {addr, data}.
REQ-020 The buffer SHALL be sub-module dl_wr_fifo (push, pop, full, empty, head entry), instantiated in both configurations.

Verification
REQ-021 Single core read addr 0x1234, mem_ack 3 cycles later with rdata 0xA5 -> one core_ack, core_rdata=0xA5.
REQ-022 dl_active=1, 4 strobes to 0x0000..0x0003 data 0x10..0x13, mem_ack latency 2 -> four writes in order, dl_overflow=0 (FIFO build).
REQ-023 Strobe and core_req same cycle, dl_active=0 -> download write issued first, core access after.
REQ-024 Strobes every cycle, mem_ack latency 5, depth 1 build -> dl_overflow=1; new dl_active rise -> dl_overflow=0.
REQ-025 reset_n=0 while mem_req=1 -> next cycle all outputs at REQ-016 values, subsequent mem_ack ignored.

Source files
------------

// File: rtl/dl_arb_pkg.sv
// dl_arb_pkg: shared arbiter FSM states and buffered download write entry.
package dl_arb_pkg;
    localparam int ENTRY_ADDR_W = 32;
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DL_WR    = 2'd1,
        CORE_ACC = 2'd2
    } arb_state_t;
    typedef struct packed {
        logic [ENTRY_ADDR_W-1:0] addr;
        logic [7:0]              data;
    } wr_entry_t;
endpackage

// File: rtl/dl_wr_fifo.sv
// dl_wr_fifo: download write buffer; DEPTH=1 is a single holding register, larger depths must be powers of two.
module dl_wr_fifo
    import dl_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      reset_n,
    input  logic      push,
    input  logic      pop,
    input  wr_entry_t din,
    output logic      full,
    output logic      empty,
    output wr_entry_t head
);
    logic do_push, do_pop;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    if (DEPTH == 1) begin : g_reg
        logic      valid;
        wr_entry_t slot;
        assign full  = valid;
        assign empty = !valid;
        assign head  = slot;
        always_ff @(posedge clk) begin
            if (do_push) slot <= din;
        end
        always_ff @(posedge clk) begin
            if (!reset_n) valid <= 1'b0;
            else          valid <= do_push || (valid && !do_pop);
        end
    end else begin : g_fifo
        localparam int PW = $clog2(DEPTH);
        wr_entry_t     slots [DEPTH];
        logic [PW-1:0] rd_ptr, wr_ptr;
        logic [PW:0]   count;
        assign full  = count[PW];
        assign empty = count == '0;
        assign head  = slots[rd_ptr];
        always_ff @(posedge clk) begin
            if (do_push) slots[wr_ptr] <= din;
        end
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + 1'b1;
                if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
                count <= count + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
            end
        end
    end
endmodule

// File: rtl/download_mem_arb.sv
// download_mem_arb: shares one memory port between buffered download writes (priority) and core accesses.
// Define DL_ARB_FIFO_EN for a DL_DEPTH-entry download FIFO; otherwise a single holding register.
module download_mem_arb
    import dl_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DL_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  dl_active,
    input  logic                  dl_wr,
    input  logic [ADDR_WIDTH-1:0] dl_addr,
    input  logic [7:0]            dl_data,
    input  logic                  core_req,
    input  logic                  core_we,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic [7:0]            core_wdata,
    output logic                  core_ack,
    output logic [7:0]            core_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    input  logic                  mem_ack,
    input  logic [7:0]            mem_rdata,
    output logic                  dl_overflow
);
`ifdef DL_ARB_FIFO_EN
    localparam int BUF_DEPTH = DL_DEPTH;
`else
    localparam int BUF_DEPTH = DL_DEPTH - DL_DEPTH + 1;
`endif
    arb_state_t state;
    wr_entry_t  din, head;
    logic       buf_full, buf_empty, pop, drop, core_grant, dl_active_q;
    logic       unused_head_bits;
    assign din.addr         = ENTRY_ADDR_W'(dl_addr);
    assign din.data         = dl_data;
    assign unused_head_bits = ^head.addr;
    assign pop  = (state == DL_WR) && mem_ack;
    assign drop = dl_wr && buf_full && !pop;
    // a strobe arriving this cycle is not yet visible as non-empty, so it must still beat the core
    assign core_grant = core_req && !dl_active && !dl_wr && !core_ack;
    dl_wr_fifo #(.DEPTH(BUF_DEPTH)) u_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (dl_wr),
        .pop     (pop),
        .din     (din),
        .full    (buf_full),
        .empty   (buf_empty),
        .head    (head)
    );
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            core_ack    <= 1'b0;
            core_rdata  <= '0;
            dl_overflow <= 1'b0;
            dl_active_q <= 1'b0;
        end else begin
            core_ack    <= 1'b0;
            dl_active_q <= dl_active;
            dl_overflow <= (dl_overflow && !(dl_active && !dl_active_q)) || drop;
            case (state)
                IDLE: begin
                    if (!buf_empty) begin
                        state     <= DL_WR;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= head.addr[ADDR_WIDTH-1:0];
                        mem_wdata <= head.data;
                    end else if (core_grant) begin
                        state     <= CORE_ACC;
                        mem_req   <= 1'b1;
                        mem_we    <= core_we;
                        mem_addr  <= core_addr;
                        mem_wdata <= core_wdata;
                    end
                end
                DL_WR: begin
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                    end
                end
                CORE_ACC: begin
                    if (mem_ack) begin
                        state    <= IDLE;
                        mem_req  <= 1'b0;
                        core_ack <= 1'b1;
                        if (!mem_we) core_rdata <= mem_rdata;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_download_mem_arb.sv
// tb_download_mem_arb: directed self-checking bench for download_mem_arb with a latency-programmable memory model.
module tb_download_mem_arb;
    localparam int AW = 16;
    logic          clk = 1'b0;
    logic          reset_n, dl_active, dl_wr, core_req, core_we;
    logic [AW-1:0] dl_addr, core_addr, mem_addr;
    logic [7:0]    dl_data, core_wdata, core_rdata, mem_wdata, mem_rdata;
    logic          core_ack, mem_req, mem_we, mem_ack, dl_overflow;
    logic          resp_ack = 1'b0, force_ack = 1'b0;
    logic [7:0]    resp_rdata = 8'h00, force_rdata = 8'h00, rd_val = 8'h00;
    int            mem_lat = 1;
    int            compared = 0, mismatched = 0;
    int            log_n = 0, ack_cnt = 0, prot_err = 0;
    logic          log_we   [64];
    logic [AW-1:0] log_addr [64];
    logic [7:0]    log_data [64];

    assign mem_ack   = resp_ack | force_ack;
    assign mem_rdata = resp_ack ? resp_rdata : force_rdata;

    download_mem_arb #(.ADDR_WIDTH(AW), .DL_DEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n), .dl_active(dl_active), .dl_wr(dl_wr),
        .dl_addr(dl_addr), .dl_data(dl_data), .core_req(core_req), .core_we(core_we),
        .core_addr(core_addr), .core_wdata(core_wdata), .core_ack(core_ack),
        .core_rdata(core_rdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .dl_overflow(dl_overflow)
    );

    always #5 clk = ~clk;

    // memory model: acks in the mem_lat-th cycle of a request and logs the access
    initial begin : responder
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk); #1;
            resp_ack = 1'b0;
            if (mem_req === 1'b1) begin
                cnt++;
                if (cnt >= mem_lat) begin
                    resp_ack   = 1'b1;
                    resp_rdata = rd_val;
                    log_we[log_n % 64]   = mem_we;
                    log_addr[log_n % 64] = mem_addr;
                    log_data[log_n % 64] = mem_wdata;
                    log_n++;
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // protocol monitor: held request fields, idle gap after ack, single-cycle core_ack
    initial begin : monitor
        logic          p_req, p_ack, p_rst, p_cack, p_we;
        logic [AW-1:0] p_addr;
        logic [7:0]    p_wd;
        p_req = 0; p_ack = 0; p_rst = 0; p_cack = 0; p_we = 0; p_addr = '0; p_wd = '0;
        forever begin
            @(negedge clk);
            if (core_ack === 1'b1) ack_cnt++;
            if (p_rst && p_req && !p_ack &&
                (mem_req !== 1'b1 || mem_we !== p_we || mem_addr !== p_addr || mem_wdata !== p_wd)) prot_err++;
            if (p_rst && p_req && p_ack && mem_req !== 1'b0) prot_err++;
            if (core_ack === 1'b1 && p_cack) prot_err++;
            p_req = mem_req; p_ack = mem_ack; p_rst = reset_n; p_cack = core_ack;
            p_we = mem_we; p_addr = mem_addr; p_wd = mem_wdata;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        reset_n = 0; dl_active = 0; dl_wr = 0; dl_addr = '0; dl_data = '0;
        core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
        tick(2);
        compared++; if (mem_req !== 1'b0) begin mismatched++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        compared++; if (mem_we !== 1'b0) begin mismatched++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        compared++; if (mem_addr !== 16'h0000) begin mismatched++; $display("FAIL reset_mem_addr: got %h want 0000", mem_addr); end
        compared++; if (mem_wdata !== 8'h00) begin mismatched++; $display("FAIL reset_mem_wdata: got %h want 00", mem_wdata); end
        compared++; if (core_ack !== 1'b0) begin mismatched++; $display("FAIL reset_core_ack: got %b want 0", core_ack); end
        compared++; if (core_rdata !== 8'h00) begin mismatched++; $display("FAIL reset_core_rdata: got %h want 00", core_rdata); end
        compared++; if (dl_overflow !== 1'b0) begin mismatched++; $display("FAIL reset_overflow: got %b want 0", dl_overflow); end
        reset_n = 1;
        tick(2);
    endtask

    task automatic test_core_read;
        int  a0 = ack_cnt, l0 = log_n;
        bit  seen = 0;
        mem_lat = 3; rd_val = 8'hA5;
        core_we = 0; core_addr = 16'h1234; core_req = 1;
        for (int i = 0; i < 30 && !seen; i++) begin tick(1); seen = core_ack; end
        core_req = 0;
        compared++; if (!seen) begin mismatched++; $display("FAIL read_ack_timeout: got no core_ack want core_ack"); end
        compared++; if (core_rdata !== 8'hA5) begin mismatched++; $display("FAIL read_rdata: got %h want a5", core_rdata); end
        tick(5);
        compared++; if (ack_cnt - a0 != 1) begin mismatched++; $display("FAIL read_ack_count: got %0d want 1", ack_cnt - a0); end
        compared++; if (log_n - l0 != 1) begin mismatched++; $display("FAIL read_mem_count: got %0d want 1", log_n - l0); end
        compared++; if (log_addr[l0 % 64] !== 16'h1234 || log_we[l0 % 64] !== 1'b0) begin
            mismatched++; $display("FAIL read_mem_access: got we=%b addr=%h want we=0 addr=1234", log_we[l0 % 64], log_addr[l0 % 64]); end
        compared++; if (core_rdata !== 8'hA5) begin mismatched++; $display("FAIL read_rdata_hold: got %h want a5", core_rdata); end
    endtask

    task automatic test_download;
        int l0 = log_n;
        bit done = 0;
        mem_lat = 2; dl_active = 1;
        tick(1);
        for (int i = 0; i < 4; i++) begin
            dl_addr = AW'(i); dl_data = 8'(8'h10 + i); dl_wr = 1;
            tick(1);
            dl_wr = 0;
`ifndef DL_ARB_FIFO_EN
            tick(7);
`endif
        end
        for (int i = 0; i < 60 && !done; i++) begin tick(1); done = (log_n - l0 >= 4); end
        compared++; if (!done) begin mismatched++; $display("FAIL dl_timeout: got %0d writes want 4", log_n - l0); end
        for (int i = 0; i < 4; i++) begin
            compared++;
            if (log_we[(l0 + i) % 64] !== 1'b1 || log_addr[(l0 + i) % 64] !== AW'(i) || log_data[(l0 + i) % 64] !== 8'(8'h10 + i)) begin
                mismatched++;
                $display("FAIL dl_write%0d: got we=%b addr=%h data=%h want we=1 addr=%h data=%h", i,
                         log_we[(l0 + i) % 64], log_addr[(l0 + i) % 64], log_data[(l0 + i) % 64], AW'(i), 8'(8'h10 + i));
            end
        end
        compared++; if (dl_overflow !== 1'b0) begin mismatched++; $display("FAIL dl_no_overflow: got %b want 0", dl_overflow); end
        dl_active = 0;
        tick(3);
    endtask

    task automatic test_priority;
        int l0 = log_n, a0 = ack_cnt;
        bit seen = 0;
        mem_lat = 1; dl_active = 0;
        dl_addr = 16'h0040; dl_data = 8'h77; dl_wr = 1;
        core_we = 1; core_addr = 16'h0050; core_wdata = 8'h88; core_req = 1;
        tick(1);
        dl_wr = 0;
        for (int i = 0; i < 30 && !seen; i++) begin tick(1); seen = core_ack; end
        core_req = 0;
        tick(3);
        compared++; if (!seen) begin mismatched++; $display("FAIL prio_ack_timeout: got no core_ack want core_ack"); end
        compared++; if (log_n - l0 != 2) begin mismatched++; $display("FAIL prio_count: got %0d want 2", log_n - l0); end
        compared++; if (log_addr[l0 % 64] !== 16'h0040 || log_data[l0 % 64] !== 8'h77 || log_we[l0 % 64] !== 1'b1) begin
            mismatched++; $display("FAIL prio_first: got we=%b addr=%h data=%h want we=1 addr=0040 data=77",
                                   log_we[l0 % 64], log_addr[l0 % 64], log_data[l0 % 64]); end
        compared++; if (log_addr[(l0 + 1) % 64] !== 16'h0050 || log_data[(l0 + 1) % 64] !== 8'h88 || log_we[(l0 + 1) % 64] !== 1'b1) begin
            mismatched++; $display("FAIL prio_second: got we=%b addr=%h data=%h want we=1 addr=0050 data=88",
                                   log_we[(l0 + 1) % 64], log_addr[(l0 + 1) % 64], log_data[(l0 + 1) % 64]); end
        compared++; if (ack_cnt - a0 != 1) begin mismatched++; $display("FAIL prio_ack_count: got %0d want 1", ack_cnt - a0); end
    endtask

    task automatic test_core_blocked;
        int a0 = ack_cnt;
        bit seen = 0, req_seen = 0;
        mem_lat = 2; rd_val = 8'h3C;
        dl_active = 1; core_we = 0; core_addr = 16'h0200; core_req = 1;
        for (int i = 0; i < 8; i++) begin tick(1); req_seen = req_seen | mem_req; end
        compared++; if (req_seen) begin mismatched++; $display("FAIL blocked_mem_req: got 1 want 0"); end
        compared++; if (ack_cnt != a0) begin mismatched++; $display("FAIL blocked_ack: got %0d acks want 0", ack_cnt - a0); end
        dl_active = 0;
        for (int i = 0; i < 30 && !seen; i++) begin tick(1); seen = core_ack; end
        core_req = 0;
        compared++; if (!seen || core_rdata !== 8'h3C) begin
            mismatched++; $display("FAIL blocked_release: got ack=%b rdata=%h want ack=1 rdata=3c", seen, core_rdata); end
        tick(3);
    endtask

    task automatic test_overflow;
        int l0 = log_n;
        mem_lat = 5; dl_active = 1;
        tick(1);
        for (int i = 0; i < 6; i++) begin
            dl_addr = AW'(16'h0100 + i); dl_data = 8'(8'h20 + i); dl_wr = 1;
            tick(1);
        end
        dl_wr = 0;
        tick(1);
        compared++; if (dl_overflow !== 1'b1) begin mismatched++; $display("FAIL ovf_set: got %b want 1", dl_overflow); end
        dl_active = 0;
        tick(80);
        compared++; if (dl_overflow !== 1'b1) begin mismatched++; $display("FAIL ovf_sticky: got %b want 1", dl_overflow); end
        compared++; if (log_addr[l0 % 64] !== 16'h0100 || log_data[l0 % 64] !== 8'h20) begin
            mismatched++; $display("FAIL ovf_first_write: got addr=%h data=%h want addr=0100 data=20", log_addr[l0 % 64], log_data[l0 % 64]); end
        dl_active = 1;
        tick(1);
        compared++; if (dl_overflow !== 1'b0) begin mismatched++; $display("FAIL ovf_clear: got %b want 0", dl_overflow); end
        dl_active = 0;
        tick(2);
    endtask

    task automatic test_reset_mid;
        int a0 = ack_cnt;
        bit seen = 0;
        mem_lat = 20; core_we = 0; core_addr = 16'h0ABC; core_req = 1;
        for (int i = 0; i < 10 && !seen; i++) begin tick(1); seen = mem_req; end
        compared++; if (!seen) begin mismatched++; $display("FAIL midrst_req_timeout: got no mem_req want mem_req"); end
        reset_n = 0;
        tick(1);
        reset_n = 1; core_req = 0;
        compared++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin
            mismatched++; $display("FAIL midrst_req: got req=%b we=%b want req=0 we=0", mem_req, mem_we); end
        compared++; if (mem_addr !== 16'h0000 || mem_wdata !== 8'h00) begin
            mismatched++; $display("FAIL midrst_addr: got addr=%h wdata=%h want 0000 00", mem_addr, mem_wdata); end
        compared++; if (core_ack !== 1'b0 || core_rdata !== 8'h00 || dl_overflow !== 1'b0) begin
            mismatched++; $display("FAIL midrst_core: got ack=%b rdata=%h ovf=%b want 0 00 0", core_ack, core_rdata, dl_overflow); end
        force_rdata = 8'h5A; force_ack = 1;
        tick(1);
        force_ack = 0;
        tick(4);
        compared++; if (ack_cnt != a0) begin mismatched++; $display("FAIL midrst_stray_ack: got %0d acks want 0", ack_cnt - a0); end
        compared++; if (core_rdata !== 8'h00 || mem_req !== 1'b0) begin
            mismatched++; $display("FAIL midrst_ignored: got rdata=%h req=%b want 00 0", core_rdata, mem_req); end
    endtask

    task automatic test_protocol;
        compared++; if (prot_err != 0) begin mismatched++; $display("FAIL protocol: got %0d violations want 0", prot_err); end
    endtask

    initial begin
        test_reset;
        test_core_read;
        test_download;
        test_priority;
        test_core_blocked;
        test_overflow;
        test_reset_mid;
        test_protocol;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
